regfile_wb: RTL and testbench

- Writeback stage plus architectural register file, directly downstream of mem.
- Consumes the memwb result bus and commits it to 8x16-bit registers.
- Provides two combinational read ports to decode, with write-through bypass.
- Tracks in-flight destination writes per register on a scoreboard, drives an operand-hazard stall, and runs a halt-drain state machine.

---
 rtl/regfile_wb_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 71 +++++++
 rtl/regfile_wb.sv | 97 +++++++++
 tb/tb_regfile_wb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the writeback stage and architectural register file.
package regfile_wb_pkg;

    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } rf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]    value;
        logic [REG_IDX_W-1:0] index;
        logic                 valid;
    } memwb_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register in-flight write counters: operand-hazard stall, sticky over/underflow
// error, and an all-clear flag on the post-edge counts for the halt drain.
module rf_scoreboard
    import regfile_wb_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 retire_valid,
    input  logic [REG_IDX_W-1:0] retire_idx,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_dest,
    input  logic                 issue_illegal,
    input  logic [REG_IDX_W-1:0] rs_idx,
    input  logic [REG_IDX_W-1:0] rt_idx,
    input  logic                 rs_used,
    input  logic                 rt_used,
    output logic                 stall,
    output logic                 sb_err,
    output logic                 all_clear_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    count      [NUM_REGS];
    logic [CNT_W-1:0]    count_next [NUM_REGS];
    logic [CNT_W-1:0]    eff_count  [NUM_REGS];
    logic [NUM_REGS-1:0] retire_match, issue_match, overflow, underflow, busy;

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        all_clear_next = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            retire_match[r] = retire_valid && (retire_idx == REG_IDX_W'(r));
            issue_match[r]  = issue_valid && (issue_dest == REG_IDX_W'(r));
            overflow[r]     = issue_match[r] && !retire_match[r] && (count[r] == CNT_MAX);
            underflow[r]    = retire_match[r] && !issue_match[r] && (count[r] == '0);
            count_next[r]   = count[r];
            if (issue_match[r] && !retire_match[r] && !overflow[r])
                count_next[r] = count[r] + 1'b1;
            else if (retire_match[r] && !issue_match[r] && !underflow[r])
                count_next[r] = count[r] - 1'b1;
            // A retiring write is already visible through the bypass, so it no longer blocks.
            eff_count[r] = (retire_match[r] && count[r] != '0) ? count[r] - 1'b1 : count[r];
            busy[r]      = (eff_count[r] != '0);
            if (count_next[r] != '0)
                all_clear_next = 1'b0;
        end
    end

    assign stall = (rs_used && busy[rs_idx]) || (rt_used && busy[rt_idx]);

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                count[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                count[r] <= count_next[r];
            if ((|overflow) || (|underflow) || issue_illegal)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Writeback stage: 8x16 register file with write-through read bypass, in-flight
// scoreboard and a RUN/DRAIN/HALTED drain machine that freezes the file once halted.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    dest_reg_value_memwb_p1,
    input  logic [REG_IDX_W-1:0] dest_reg_index_memwb_p1,
    input  logic                 dest_reg_write_valid_memwb_p1,
    input  logic [REG_IDX_W-1:0] rs_idx_idrf_p1,
    input  logic [REG_IDX_W-1:0] rt_idx_idrf_p1,
    output logic [DATA_W-1:0]    rs_value_rfid_p1,
    output logic [DATA_W-1:0]    rt_value_rfid_p1,
    input  logic                 rs_used_idrf_p1,
    input  logic                 rt_used_idrf_p1,
    input  logic                 issue_valid_idrf_p1,
    input  logic [REG_IDX_W-1:0] issue_dest_idrf_p1,
    input  logic                 halt_idrf_p1,
    output logic                 stall_rfid_p1,
    output logic                 halted_rfif_p1,
    output logic                 sb_err_p1
);

    rf_state_e         state, state_next;
    memwb_t            wb;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              frozen, all_clear_next;

    assign frozen = (state == HALTED);

    // Once halted, incoming writebacks neither commit, bypass nor retire.
    assign wb = '{value: dest_reg_value_memwb_p1,
                  index: dest_reg_index_memwb_p1,
                  valid: dest_reg_write_valid_memwb_p1 && !frozen};

    // NOTE: the array is small and must read as zero after reset, so it is built
    // from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (wb.valid) begin
            regs[wb.index] <= wb.value;
        end
    end

    always_comb begin
        rs_value_rfid_p1 = (wb.valid && wb.index == rs_idx_idrf_p1) ? wb.value : regs[rs_idx_idrf_p1];
        rt_value_rfid_p1 = (wb.valid && wb.index == rt_idx_idrf_p1) ? wb.value : regs[rt_idx_idrf_p1];
    end

    rf_scoreboard #(
        .NUM_REGS(NUM_REGS),
        .CNT_W   (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .retire_valid  (wb.valid),
        .retire_idx    (wb.index),
        .issue_valid   (issue_valid_idrf_p1 && !frozen),
        .issue_dest    (issue_dest_idrf_p1),
        .issue_illegal (issue_valid_idrf_p1 && frozen),
        .rs_idx        (rs_idx_idrf_p1),
        .rt_idx        (rt_idx_idrf_p1),
        .rs_used       (rs_used_idrf_p1),
        .rt_used       (rt_used_idrf_p1),
        .stall         (stall_rfid_p1),
        .sb_err        (sb_err_p1),
        .all_clear_next(all_clear_next)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt_idrf_p1) state_next = all_clear_next ? HALTED : DRAIN;
            DRAIN:   if (all_clear_next) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        halted_rfif_p1 = (state == HALTED);
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus randomized traffic,
// all compared against an abstract model of the register file and pending counts.
module tb_regfile_wb;

    localparam int MAX_PEND = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wval;
    logic [2:0]  widx, rs, rt, idest;
    logic        wv, rs_used, rt_used, iv, halt;
    logic [15:0] rs_val, rt_val;
    logic        stall, halted, sb_err;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk                          (clk),
        .rst                          (rst),
        .dest_reg_value_memwb_p1      (wval),
        .dest_reg_index_memwb_p1      (widx),
        .dest_reg_write_valid_memwb_p1(wv),
        .rs_idx_idrf_p1               (rs),
        .rt_idx_idrf_p1               (rt),
        .rs_value_rfid_p1             (rs_val),
        .rt_value_rfid_p1             (rt_val),
        .rs_used_idrf_p1              (rs_used),
        .rt_used_idrf_p1              (rt_used),
        .issue_valid_idrf_p1          (iv),
        .issue_dest_idrf_p1           (idest),
        .halt_idrf_p1                 (halt),
        .stall_rfid_p1                (stall),
        .halted_rfif_p1               (halted),
        .sb_err_p1                    (sb_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural values, outstanding writes per register, flags.
    logic [15:0] m_regs [8];
    int          m_cnt  [8];
    bit          m_err, m_draining, m_halted;
    logic [15:0] exp_rs, exp_rt;
    bit          exp_stall;

    task automatic idle();
        rst = 1'b0; wv = 1'b0; wval = '0; widx = '0; rs = '0; rt = '0;
        rs_used = 1'b0; rt_used = 1'b0; iv = 1'b0; idest = '0; halt = 1'b0;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] idx);
        if (wv && !m_halted && widx == idx) return wval;
        return m_regs[idx];
    endfunction

    function automatic bit m_busy(input logic [2:0] idx);
        int left = m_cnt[idx];
        if (wv && !m_halted && widx == idx && left > 0) left--;
        return left != 0;
    endfunction

    task automatic predict();
        #1;
        exp_rs    = m_read(rs);
        exp_rt    = m_read(rt);
        exp_stall = (rs_used && m_busy(rs)) || (rt_used && m_busy(rt));
    endtask

    function automatic string got_str();
        return $sformatf("got rs=%h rt=%h stall=%b halted=%b err=%b", rs_val, rt_val, stall, halted, sb_err);
    endfunction

    function automatic string want_str();
        return $sformatf("want rs=%h rt=%h stall=%b halted=%b err=%b", exp_rs, exp_rt, exp_stall, m_halted, m_err);
    endfunction

    // Advance the model by the spec's rules for the currently driven inputs, then clock.
    task automatic tick();
        bit retire, issue;
        int pending;
        if (rst) begin
            for (int r = 0; r < 8; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
            m_err = 0; m_draining = 0; m_halted = 0;
        end else begin
            retire = wv && !m_halted;
            issue  = iv && !m_halted;
            if (iv && m_halted) m_err = 1;
            if (retire) m_regs[widx] = wval;
            if (issue && !(retire && widx == idest)) begin
                if (m_cnt[idest] == MAX_PEND) m_err = 1; else m_cnt[idest]++;
            end
            if (retire && !(issue && widx == idest)) begin
                if (m_cnt[widx] == 0) m_err = 1; else m_cnt[widx]--;
            end
            pending = 0;
            for (int r = 0; r < 8; r++) pending += m_cnt[r];
            if (!m_halted && (m_draining || halt)) begin
                if (pending == 0) begin m_halted = 1; m_draining = 0; end
                else m_draining = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle(); rs = 3'(i); rt = 3'(7 - i); rs_used = 1'b1; rt_used = 1'b1;
            predict();
            n_tests++;
            if ({rs_val, rt_val, stall, halted, sb_err} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL reset_sweep[%0d]: %s, want all zero", i, got_str());
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        do_reset();
        idle(); iv = 1'b1; idest = 3'd3; tick();
        idle(); wv = 1'b1; widx = 3'd3; wval = 16'hBEEF; rs = 3'd3; rs_used = 1'b1;
        predict();
        n_tests++;
        if (rs_val !== 16'hBEEF || stall !== 1'b0 || {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
            n_fail++; $display("FAIL bypass_commit: %s, %s", got_str(), want_str());
        end
        tick();
        idle(); rs = 3'd3; rt = 3'd3;
        predict();
        n_tests++;
        if (rs_val !== 16'hBEEF || rt_val !== 16'hBEEF || {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
            n_fail++; $display("FAIL array_read: %s, %s", got_str(), want_str());
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        idle(); iv = 1'b1; idest = 3'd5; rs = 3'd5; rs_used = 1'b1;
        predict();
        n_tests++;
        if (stall !== 1'b0 || {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
            n_fail++; $display("FAIL stall_issue_cycle: %s, %s", got_str(), want_str());
        end
        tick();
        for (int c = 1; c <= 2; c++) begin
            idle(); rs = 3'd5; rs_used = 1'b1;
            predict();
            n_tests++;
            if (stall !== 1'b1 || {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
                n_fail++; $display("FAIL stall_pending[n+%0d]: %s, %s", c, got_str(), want_str());
            end
            tick();
        end
        idle(); wv = 1'b1; widx = 3'd5; wval = 16'h1234; rs = 3'd5; rs_used = 1'b1;
        predict();
        n_tests++;
        if (stall !== 1'b0 || rs_val !== 16'h1234 || {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
            n_fail++; $display("FAIL stall_release: %s, %s", got_str(), want_str());
        end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle(); iv = (c < 4); idest = 3'd2; rt = 3'd2; rt_used = 1'b1;
            predict();
            n_tests++;
            if (sb_err !== (c >= 4) || {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
                n_fail++; $display("FAIL saturate[%0d]: %s, %s", c, got_str(), want_str());
            end
            tick();
        end
        do_reset();
        for (int c = 0; c < 2; c++) begin
            idle(); wv = (c == 0); widx = 3'd6; wval = 16'h5A5A; rs = 3'd6;
            predict();
            n_tests++;
            if (sb_err !== (c == 1) || {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
                n_fail++; $display("FAIL underflow[%0d]: %s, %s", c, got_str(), want_str());
            end
            tick();
        end
    endtask

    task automatic test_halt();
        do_reset();
        idle(); iv = 1'b1; idest = 3'd7; tick();
        idle(); wv = 1'b1; widx = 3'd7; wval = 16'h00A5; tick();
        idle(); iv = 1'b1; idest = 3'd1; tick();
        idle(); iv = 1'b1; idest = 3'd4; tick();
        idle(); halt = 1'b1; tick();
        // cycle 0: retire R1, 1: idle, 2: retire R4, 3: halted, 4: ignored R7 write, 5: read R7, 6: illegal issue
        for (int c = 0; c < 8; c++) begin
            idle(); rs = 3'd7; rt = 3'd4; rt_used = 1'b1;
            case (c)
                0: begin wv = 1'b1; widx = 3'd1; wval = 16'h1111; end
                2: begin wv = 1'b1; widx = 3'd4; wval = 16'h4444; end
                4: begin wv = 1'b1; widx = 3'd7; wval = 16'hFFFF; end
                6: begin iv = 1'b1; idest = 3'd0; end
                default: ;
            endcase
            predict();
            n_tests++;
            if (halted !== (c >= 3) || rs_val !== 16'h00A5 || sb_err !== (c == 7) ||
                {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
                n_fail++; $display("FAIL halt_drain[%0d]: %s, %s", c, got_str(), want_str());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        idle(); iv = 1'b1; idest = 3'd0; tick();
        idle(); wv = 1'b1; widx = 3'd0; wval = 16'h1111; tick();
        idle(); iv = 1'b1; idest = 3'd3; tick();
        idle(); iv = 1'b1; idest = 3'd5; tick();
        idle(); halt = 1'b1; tick();
        idle(); tick();
        idle(); rst = 1'b1; tick();
        for (int c = 0; c < 2; c++) begin
            idle(); rs = (c == 0) ? 3'd0 : 3'd3; rt = 3'd5; rs_used = 1'b1; rt_used = 1'b1;
            predict();
            n_tests++;
            if ({rs_val, rt_val, stall, halted, sb_err} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b0} ||
                {rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
                n_fail++; $display("FAIL reset_mid_drain[%0d]: %s, %s", c, got_str(), want_str());
            end
            tick();
        end
    endtask

    task automatic test_random();
        int pend_list [$];
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            rs = 3'($urandom_range(0, 7)); rt = 3'($urandom_range(0, 7));
            rs_used = 1'($urandom); rt_used = 1'($urandom);
            pend_list.delete();
            for (int r = 0; r < 8; r++) if (m_cnt[r] > 0) pend_list.push_back(r);
            if ($urandom_range(0, 2) != 0) begin
                wv = 1'b1; wval = 16'($urandom);
                if (pend_list.size() > 0 && $urandom_range(0, 9) != 0)
                    widx = 3'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
                else
                    widx = 3'($urandom_range(0, 7));
            end
            iv = ($urandom_range(0, 2) == 0); idest = 3'($urandom_range(0, 7));
            halt = ($urandom_range(0, 40) == 0);
            if (m_halted && $urandom_range(0, 5) == 0) rst = 1'b1;
            predict();
            n_tests++;
            if ({rs_val, rt_val, stall, halted, sb_err} !== {exp_rs, exp_rt, exp_stall, m_halted, m_err}) begin
                n_fail++; $display("FAIL random[%0d]: %s, %s", c, got_str(), want_str());
            end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_stall();
        test_saturate();
        test_halt();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
